m6502_status_reg: RTL and testbench
===================================

// Module: m6502_status_reg
// PURPOSE
//  Processor status (P) register of the m6502 core: consumes ALU result/carry/overflow and updates N V D I Z C.
//  Provides the P byte for PHP/BRK pushes and loads it from the data bus on PLP/RTI.
//  Owns interrupt gating: one-instruction-delayed I mask, NMI edge latch and IRQ request.
//  Sits between the ALU (alu_log/alu_add outputs) and the control sequencer.
// PARAMETERS
//  RST_P     8'h24  P value after reset (bit5=1, I=1, all others 0)
//  NMI_SYNC  2      NMI synchroniser depth in flops, >=2
// PORTS
//  clk        in   1  core clock
//  rst_n      in   1  reset, asynchronous, active-low
//  en         in   1  clock enable (RDY); low -> P, i_eff and irq_req hold
//  flag_op    in   3  flag update selector (encoding in m6502_pkg)
//  alu_y      in   8  ALU result
//  alu_cout   in   1  ALU carry out
//  alu_vout   in   1  ALU overflow out
//  p_din      in   8  data bus byte (PULL source; BIT memory operand)
//  fsel       in   2  SETCLR target: 0=C 1=I 2=D 3=V
//  fval       in   1  SETCLR value (V accepts only 0)
//  b_push     in   1  value driven on p_out[4] (1 for PHP/BRK, 0 for IRQ/NMI)
//  sync_i     in   1  instruction-boundary strobe (opcode fetch cycle)
//  intr_entry in   1  interrupt sequence entry: set I and i_eff at once
//  irq_n      in   1  level IRQ, active-low
//  nmi_n      in   1  edge NMI, active-low, asynchronous
//  nmi_ack    in   1  NMI vector taken, clear pending
//  p_out      out  8  {N,V,1,b_push,D,I,Z,C}, combinational from regs
//  irq_req    out  1  registered: IRQ asserted and not masked
//  nmi_pend   out  1  registered NMI pending
// BEHAVIOUR
//  Reset: N=V=D=Z=C=0, I=1, i_eff=1, irq_req=0, nmi_pend=0, sync flops=1; p_out=8'h24 (b_push=0).
//  All flag updates take effect at the clk edge with en=1; latency 1 cycle.
//  flag_op: 000 HOLD; 001 NZ: N=alu_y[7], Z=(alu_y==0);
//   010 NZCV: NZ as 001, C=alu_cout, V=alu_vout; 011 NZC: NZ, C=alu_cout (shift/rotate/compare);
//   100 BIT: Z=(alu_y==0), N=p_din[7], V=p_din[6]; 101 PULL: P<=p_din, bits 5/4 ignored;
//   110 SETCLR: flag[fsel]<=fval, fsel=3 with fval=1 -> no change; 111 reserved -> HOLD.
//  i_eff (mask used for IRQ): copies I at the first sync_i edge with en=1 after I changes -> CLI/SEI/PLP
//   take effect one instruction late. If I changes and sync_i in same cycle, i_eff gets the OLD I.
//  intr_entry (en=1): I<=1 and i_eff<=1 same edge; overrides SETCLR/PULL writes to I that cycle.
//  irq_req <= ~irq_n & ~i_eff each en edge; holds when en=0.
//  NMI: nmi_n through NMI_SYNC flops on every clk (independent of en); synced falling edge sets nmi_pend.
//   nmi_ack clears it; edge and ack same cycle -> nmi_pend stays 1. Held-low nmi_n raises one request only.
//  Reset mid-instruction: all state to reset values immediately; pending NMI is lost.
// CONFIGURATION
//  M6502_DECIMAL_EN defined: D flag stored and reported normally.
//  Undefined: D forced 0 (no flop); SETCLR fsel=2 and PULL bit3 ignored; p_out[3]=0 (2A03-style core).
// STRUCTURE
//  m6502_pkg: P bit indices (C=0 Z=1 I=2 D=3 B=4 U=5 V=6 N=7), FLAG_OP_* localparams, FSEL_* codes, RST_P default.
//  Sub-module m6502_nmi_edge: synchroniser + falling-edge detect + pending latch (nmi_n, nmi_ack -> nmi_pend).
// TESTING
//  flag_op=010, alu_y=8'h00, cout=1, vout=1 -> p_out=8'h67 with b_push=0 (N0 V1 Z1 C1, I still 1).
//  flag_op=100, alu_y=8'h00, p_din=8'hC0 -> N=1,V=1,Z=1; C unchanged.
//  SETCLR I=0 then irq_n=0: irq_req stays 0 until second sync_i edge, then 1 one cycle later.
//  intr_entry with same-cycle SETCLR I=0 -> I=1, i_eff=1, irq_req deasserts next en edge.
//  nmi_n pulse low 3 cycles -> nmi_pend=1 at NMI_SYNC+1 cycles; ack coincident with 2nd edge -> stays 1.
//  PULL p_din=8'hFF: DECIMAL_EN -> p_out=8'hEF (b_push=0); undefined -> 8'hE7; en=0 any op -> P unchanged.

Source files
------------

// File: rtl/m6502_pkg.sv
// Shared definitions for the m6502 core: P bit positions, flag update opcodes,
// SETCLR target codes and the architectural reset value of P.
package m6502_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [2:0] FLAG_OP_HOLD   = 3'b000;
  localparam logic [2:0] FLAG_OP_NZ     = 3'b001;
  localparam logic [2:0] FLAG_OP_NZCV   = 3'b010;
  localparam logic [2:0] FLAG_OP_NZC    = 3'b011;
  localparam logic [2:0] FLAG_OP_BIT    = 3'b100;
  localparam logic [2:0] FLAG_OP_PULL   = 3'b101;
  localparam logic [2:0] FLAG_OP_SETCLR = 3'b110;
  localparam logic [2:0] FLAG_OP_RSVD   = 3'b111;

  localparam logic [1:0] FSEL_C = 2'd0;
  localparam logic [1:0] FSEL_I = 2'd1;
  localparam logic [1:0] FSEL_D = 2'd2;
  localparam logic [1:0] FSEL_V = 2'd3;

  localparam logic [7:0] RST_P_DEFAULT = 8'h24;

  // Flags that always have storage; D lives apart because it may be compiled out.
  typedef struct packed {
    logic n;
    logic v;
    logic i;
    logic z;
    logic c;
  } flags_t;

  function automatic logic is_zero(input logic [7:0] y);
    return (y == 8'h00);
  endfunction

endpackage

// File: rtl/m6502_nmi_edge.sv
// NMI front end: synchronises the asynchronous nmi_n, detects its falling edge
// and holds a pending request until the sequencer acknowledges the vector.
module m6502_nmi_edge #(
  parameter int NMI_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n,
  input  logic nmi_ack,
  output logic nmi_pend
);

  logic [NMI_SYNC-1:0] sync_q;
  logic                last_q;
  logic                fall;

  // Only a high-to-low transition of the synchronised line counts, so a
  // held-low nmi_n produces a single request.
  assign fall = last_q & ~sync_q[NMI_SYNC-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      last_q   <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q   <= {sync_q[NMI_SYNC-2:0], nmi_n};
      last_q   <= sync_q[NMI_SYNC-1];
      nmi_pend <= fall | (nmi_pend & ~nmi_ack);
    end
  end

endmodule

// File: rtl/m6502_status_reg.sv
// m6502 processor status register with delayed I mask, IRQ request and NMI latch.
// Define M6502_DECIMAL_EN to store the D flag; otherwise D reads as 0 (2A03 style).
module m6502_status_reg
  import m6502_pkg::*;
#(
  parameter logic [7:0] RST_P    = RST_P_DEFAULT,
  parameter int         NMI_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] flag_op,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_vout,
  input  logic [7:0] p_din,
  input  logic [1:0] fsel,
  input  logic       fval,
  input  logic       b_push,
  input  logic       sync_i,
  input  logic       intr_entry,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic [7:0] p_out,
  output logic       irq_req,
  output logic       nmi_pend
);

  flags_t f_q;
  flags_t f_nxt;
  logic   i_eff_q;
  logic   d_bit;

`ifdef M6502_DECIMAL_EN
  logic d_q;
  logic d_nxt;
  logic unused_bits;
  assign unused_bits = ^p_din[P_U:P_B];
`else
  logic unused_bits;
  assign unused_bits = ^p_din[P_U:P_D];
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statements can infer a latch.
    f_nxt = f_q;
`ifdef M6502_DECIMAL_EN
    d_nxt = d_q;
`endif
    case (flag_op)
      FLAG_OP_NZ: begin
        f_nxt.n = alu_y[7];
        f_nxt.z = is_zero(alu_y);
      end
      FLAG_OP_NZCV: begin
        f_nxt.n = alu_y[7];
        f_nxt.z = is_zero(alu_y);
        f_nxt.c = alu_cout;
        f_nxt.v = alu_vout;
      end
      FLAG_OP_NZC: begin
        f_nxt.n = alu_y[7];
        f_nxt.z = is_zero(alu_y);
        f_nxt.c = alu_cout;
      end
      FLAG_OP_BIT: begin
        f_nxt.z = is_zero(alu_y);
        f_nxt.n = p_din[P_N];
        f_nxt.v = p_din[P_V];
      end
      FLAG_OP_PULL: begin
        f_nxt = '{n: p_din[P_N], v: p_din[P_V], i: p_din[P_I],
                  z: p_din[P_Z], c: p_din[P_C]};
`ifdef M6502_DECIMAL_EN
        d_nxt = p_din[P_D];
`endif
      end
      FLAG_OP_SETCLR: begin
        case (fsel)
          FSEL_C: f_nxt.c = fval;
          FSEL_I: f_nxt.i = fval;
          FSEL_D: begin
`ifdef M6502_DECIMAL_EN
            d_nxt = fval;
`endif
          end
          FSEL_V: if (!fval) f_nxt.v = 1'b0;  // there is no SEV
          default: ;
        endcase
      end
      default: ;  // HOLD and the reserved code
    endcase
    // Interrupt entry masks IRQ unconditionally, winning over any I write.
    if (intr_entry) f_nxt.i = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '{n: RST_P[P_N], v: RST_P[P_V], i: RST_P[P_I],
                   z: RST_P[P_Z], c: RST_P[P_C]};
      i_eff_q <= RST_P[P_I];
      irq_req <= 1'b0;
    end else if (en) begin
      f_q <= f_nxt;
      // Sampling the pre-edge I at the opcode fetch delays CLI/SEI/PLP by one instruction.
      if (intr_entry)  i_eff_q <= 1'b1;
      else if (sync_i) i_eff_q <= f_q.i;
      irq_req <= ~irq_n & ~i_eff_q;
    end
  end

`ifdef M6502_DECIMAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  d_q <= RST_P[P_D];
    else if (en) d_q <= d_nxt;
  end
  assign d_bit = d_q;
`else
  assign d_bit = 1'b0;
`endif

  assign p_out = {f_q.n, f_q.v, 1'b1, b_push, d_bit, f_q.i, f_q.z, f_q.c};

  m6502_nmi_edge #(
    .NMI_SYNC(NMI_SYNC)
  ) u_nmi_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .nmi_n   (nmi_n),
    .nmi_ack (nmi_ack),
    .nmi_pend(nmi_pend)
  );

endmodule

// File: tb/tb_m6502_status_reg.sv
// Bench for m6502_status_reg: directed literal checks plus random stimulus
// compared every cycle against a byte-level model of the P register.
module tb_m6502_status_reg;

  localparam int NMI_SYNC = 2;
`ifdef M6502_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, fval, alu_cout, alu_vout, b_push, sync_i, intr_entry;
  logic       irq_n, nmi_n, nmi_ack;
  logic [2:0] flag_op;
  logic [7:0] alu_y, p_din;
  logic [1:0] fsel;
  logic [7:0] p_out;
  logic       irq_req, nmi_pend;

  int checks = 0;
  int errors = 0;

  // Reference state: P as a byte (bit5=1, bit4 kept 0), effective mask, outputs,
  // and the raw nmi_n samples taken at each edge (index 0 = newest).
  bit [7:0] mp;
  bit       m_ieff, m_irq, m_pend;
  bit       hist [NMI_SYNC+2];

  always #5 clk = ~clk;

  m6502_status_reg #(.RST_P(8'h24), .NMI_SYNC(NMI_SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flag_op(flag_op), .alu_y(alu_y),
    .alu_cout(alu_cout), .alu_vout(alu_vout), .p_din(p_din), .fsel(fsel),
    .fval(fval), .b_push(b_push), .sync_i(sync_i), .intr_entry(intr_entry),
    .irq_n(irq_n), .nmi_n(nmi_n), .nmi_ack(nmi_ack), .p_out(p_out),
    .irq_req(irq_req), .nmi_pend(nmi_pend)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    en = 1'b1; flag_op = 3'b000; alu_y = 8'h00; alu_cout = 1'b0; alu_vout = 1'b0;
    p_din = 8'h00; fsel = 2'd0; fval = 1'b0; b_push = 1'b0; sync_i = 1'b0;
    intr_entry = 1'b0; nmi_ack = 1'b0;
  endtask

  task automatic model_reset();
    mp = 8'h24; m_ieff = 1'b1; m_irq = 1'b0; m_pend = 1'b0;
    for (int k = 0; k < NMI_SYNC + 2; k++) hist[k] = 1'b1;
  endtask

  task automatic model_edge();
    bit [7:0] mask;
    bit       old_i;
    int       idx [4];
    idx = '{0, 2, 3, 6};
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = NMI_SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = nmi_n;
    m_pend = (hist[NMI_SYNC+1] & ~hist[NMI_SYNC]) | (m_pend & ~nmi_ack);
    if (en) begin
      old_i = mp[2];
      m_irq = ~irq_n & ~m_ieff;
      case (flag_op)
        3'd1: begin mp[7] = alu_y[7]; mp[1] = (alu_y == 0); end
        3'd2: begin mp[7] = alu_y[7]; mp[1] = (alu_y == 0); mp[0] = alu_cout; mp[6] = alu_vout; end
        3'd3: begin mp[7] = alu_y[7]; mp[1] = (alu_y == 0); mp[0] = alu_cout; end
        3'd4: begin mp[1] = (alu_y == 0); mp[7] = p_din[7]; mp[6] = p_din[6]; end
        3'd5: begin
          mask = DEC ? 8'hCF : 8'hC7;
          mp = (p_din & mask) | (mp & ~mask);
        end
        3'd6: if (!(fsel == 2'd3 && fval) && !(fsel == 2'd2 && !DEC)) mp[idx[fsel]] = fval;
        default: ;
      endcase
      if (intr_entry) begin
        mp[2] = 1'b1;
        m_ieff = 1'b1;
      end else if (sync_i) begin
        m_ieff = old_i;
      end
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("p_out", p_out, mp | {3'b000, b_push, 4'b0000});
    check("irq_req", {7'd0, irq_req}, {7'd0, m_irq});
    check("nmi_pend", {7'd0, nmi_pend}, {7'd0, m_pend});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    irq_n = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    irq_n = 1'b1;
    nmi_n = 1'b1;
    model_reset();

    do_reset();
    check("reset_p", p_out, 8'h24);
    check("reset_irq", {7'd0, irq_req}, 8'h00);
    check("reset_nmi", {7'd0, nmi_pend}, 8'h00);

    flag_op = 3'd2; alu_y = 8'h00; alu_cout = 1'b1; alu_vout = 1'b1;
    cyc();
    check("nzcv_lit", p_out, 8'h67);

    idle(); flag_op = 3'd4; alu_y = 8'h00; p_din = 8'hC0;
    cyc();
    check("bit_lit", p_out, 8'hE7);

    idle(); en = 1'b0; flag_op = 3'd5; p_din = 8'h00;
    cyc();
    check("en0_hold", p_out, 8'hE7);

    idle(); flag_op = 3'd5; p_din = 8'hFF;
    cyc();
    check("pull_ff", p_out, DEC ? 8'hEF : 8'hE7);
    idle(); b_push = 1'b1;
    cyc();
    check("b_push", p_out, DEC ? 8'hFF : 8'hF7);

    // CLI with overlapping fetch: IRQ only after the second instruction boundary.
    do_reset();
    irq_n = 1'b0;
    flag_op = 3'd6; fsel = 2'd1; fval = 1'b0; sync_i = 1'b1;
    cyc();
    check("cli_p", p_out, 8'h20);
    check("cli_irq_a", {7'd0, irq_req}, 8'h00);
    idle(); cyc();
    check("cli_irq_b", {7'd0, irq_req}, 8'h00);
    sync_i = 1'b1; cyc();
    check("cli_irq_sync2", {7'd0, irq_req}, 8'h00);
    sync_i = 1'b0; cyc();
    check("cli_irq_on", {7'd0, irq_req}, 8'h01);

    flag_op = 3'd6; fsel = 2'd1; fval = 1'b0; intr_entry = 1'b1;
    cyc();
    check("intr_i", p_out, 8'h24);
    check("intr_irq_same", {7'd0, irq_req}, 8'h01);
    idle(); cyc();
    check("intr_irq_off", {7'd0, irq_req}, 8'h00);
    irq_n = 1'b1;

    // NMI: pulse of three edges, then a second pulse acked on its detect edge.
    nmi_n = 1'b0;
    cyc(); cyc();
    check("nmi_early", {7'd0, nmi_pend}, 8'h00);
    cyc();
    check("nmi_set", {7'd0, nmi_pend}, 8'h01);
    nmi_n = 1'b1;
    repeat (3) cyc();
    nmi_n = 1'b0;
    cyc(); cyc();
    nmi_ack = 1'b1; cyc();
    check("nmi_ack_edge", {7'd0, nmi_pend}, 8'h01);
    nmi_n = 1'b1; nmi_ack = 1'b0; cyc();
    nmi_ack = 1'b1; cyc();
    check("nmi_ack", {7'd0, nmi_pend}, 8'h00);
    nmi_ack = 1'b0;
    nmi_n = 1'b0;
    repeat (3) cyc();
    nmi_ack = 1'b1; cyc();
    nmi_ack = 1'b0;
    repeat (6) cyc();
    check("nmi_held", {7'd0, nmi_pend}, 8'h00);
    nmi_n = 1'b1;
    repeat (2) cyc();
    nmi_n = 1'b0;
    repeat (4) cyc();
    check("nmi_pre_rst", {7'd0, nmi_pend}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_async_nmi", {7'd0, nmi_pend}, 8'h00);
    check("rst_async_p", p_out, 8'h24);
    nmi_n = 1'b1;
    do_reset();

    // Random phase with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      en         = ($urandom_range(0, 9) != 0);
      flag_op    = 3'($urandom_range(0, 7));
      alu_y      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      alu_cout   = 1'($urandom);
      alu_vout   = 1'($urandom);
      p_din      = 8'($urandom);
      fsel       = 2'($urandom);
      fval       = 1'($urandom);
      b_push     = 1'($urandom);
      sync_i     = ($urandom_range(0, 2) == 0);
      intr_entry = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      nmi_ack    = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
